// File: rtl/tdd_seq_ctrl.sv
// Multi-antenna TDD sequencer: guarded direction change, staggered enables.
// Optional macro TDD_ABORT_CNT_EN adds a saturating 16-bit abort counter.
module tdd_seq_ctrl #(
   parameter int ANT_NUM = 8,
   parameter int CNT_W   = 12,
   parameter int STEP    = 4
) (
   input  logic               clk_in,
   input  logic               rst,
   input  logic               i_tx_req,
   input  logic [ANT_NUM-1:0] i_ant_mask,
   input  logic [CNT_W-1:0]   i_tx_guard,
   input  logic [CNT_W-1:0]   i_rx_guard,
   output logic [ANT_NUM-1:0] o_tx_en,
   output logic [ANT_NUM-1:0] o_rx_en,
   output logic               o_tx_stt,
   output logic               o_rx_stt,
   output logic [2:0]         o_state,
   output logic               o_abort
`ifdef TDD_ABORT_CNT_EN
   ,
   output logic [15:0]        o_abort_cnt
`endif
);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_TX_GUARD = 3'd1;
   localparam logic [2:0] S_TX_RAMP  = 3'd2;
   localparam logic [2:0] S_TX_ON    = 3'd3;
   localparam logic [2:0] S_RX_GUARD = 3'd4;
   localparam logic [2:0] S_RX_RAMP  = 3'd5;
   localparam logic [2:0] S_RX_ON    = 3'd6;

   localparam int SW = (STEP > 1) ? $clog2(STEP) : 1;
   localparam logic [SW-1:0] STEP_RLD = SW'(STEP - 1);

   logic               req_q;
   logic [2:0]         state;
   logic [CNT_W-1:0]   gcnt;
   logic [SW-1:0]      scnt;
   logic [ANT_NUM-1:0] pend;
   logic [ANT_NUM-1:0] low;
   logic [ANT_NUM-1:0] rest;
   logic               guard_done;
   logic               pend_empty;
   logic               step_due;

   // lowest pending antenna is the next one to enable
   assign low        = pend & (~pend + ANT_NUM'(1));
   assign rest       = pend & ~low;
   assign guard_done = (gcnt <= CNT_W'(1));
   assign pend_empty = (pend == '0);
   assign step_due   = (scnt == '0);
   assign o_state    = state;

   always_ff @(posedge clk_in) begin
      req_q <= i_tx_req;
      if (rst) begin
         state    <= S_IDLE;
         o_tx_en  <= '0;
         o_rx_en  <= '0;
         o_tx_stt <= 1'b0;
         o_rx_stt <= 1'b0;
         o_abort  <= 1'b0;
         gcnt     <= '0;
         scnt     <= '0;
         pend     <= '0;
      end else begin
         o_abort <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req_q) begin
                  state    <= S_TX_GUARD;
                  o_tx_en  <= '0;
                  o_tx_stt <= 1'b0;
                  o_rx_en  <= '0;
                  o_rx_stt <= 1'b0;
                  gcnt     <= i_tx_guard;
                  pend     <= i_ant_mask;
               end
            end
            S_TX_GUARD: begin
               if (!req_q) begin
                  o_abort  <= 1'b1;
                  state    <= S_RX_GUARD;
                  o_tx_en  <= '0;
                  o_tx_stt <= 1'b0;
                  gcnt     <= i_rx_guard;
                  pend     <= i_ant_mask;
               end else if (guard_done) begin
                  state   <= S_TX_RAMP;
                  o_tx_en <= o_tx_en | low;
                  pend    <= rest;
                  scnt    <= STEP_RLD;
               end else begin
                  gcnt <= gcnt - CNT_W'(1);
               end
            end
            S_TX_RAMP: begin
               if (!req_q) begin
                  o_abort  <= 1'b1;
                  state    <= S_RX_GUARD;
                  o_tx_en  <= '0;
                  o_tx_stt <= 1'b0;
                  gcnt     <= i_rx_guard;
                  pend     <= i_ant_mask;
               end else if (pend_empty) begin
                  state    <= S_TX_ON;
                  o_tx_stt <= 1'b1;
               end else if (step_due) begin
                  o_tx_en <= o_tx_en | low;
                  pend    <= rest;
                  scnt    <= STEP_RLD;
                  if (rest == '0) begin
                     state    <= S_TX_ON;
                     o_tx_stt <= 1'b1;
                  end
               end else begin
                  scnt <= scnt - SW'(1);
               end
            end
            S_TX_ON: begin
               if (!req_q) begin
                  state    <= S_RX_GUARD;
                  o_tx_en  <= '0;
                  o_tx_stt <= 1'b0;
                  gcnt     <= i_rx_guard;
                  pend     <= i_ant_mask;
               end
            end
            S_RX_GUARD: begin
               if (req_q) begin
                  o_abort  <= 1'b1;
                  state    <= S_TX_GUARD;
                  o_rx_en  <= '0;
                  o_rx_stt <= 1'b0;
                  gcnt     <= i_tx_guard;
                  pend     <= i_ant_mask;
               end else if (guard_done) begin
                  state   <= S_RX_RAMP;
                  o_rx_en <= o_rx_en | low;
                  pend    <= rest;
                  scnt    <= STEP_RLD;
               end else begin
                  gcnt <= gcnt - CNT_W'(1);
               end
            end
            S_RX_RAMP: begin
               if (req_q) begin
                  o_abort  <= 1'b1;
                  state    <= S_TX_GUARD;
                  o_rx_en  <= '0;
                  o_rx_stt <= 1'b0;
                  gcnt     <= i_tx_guard;
                  pend     <= i_ant_mask;
               end else if (pend_empty) begin
                  state    <= S_RX_ON;
                  o_rx_stt <= 1'b1;
               end else if (step_due) begin
                  o_rx_en <= o_rx_en | low;
                  pend    <= rest;
                  scnt    <= STEP_RLD;
                  if (rest == '0) begin
                     state    <= S_RX_ON;
                     o_rx_stt <= 1'b1;
                  end
               end else begin
                  scnt <= scnt - SW'(1);
               end
            end
            S_RX_ON: begin
               if (req_q) begin
                  state    <= S_TX_GUARD;
                  o_rx_en  <= '0;
                  o_rx_stt <= 1'b0;
                  gcnt     <= i_tx_guard;
                  pend     <= i_ant_mask;
               end
            end
            default: begin
               state    <= S_IDLE;
               o_tx_en  <= '0;
               o_rx_en  <= '0;
               o_tx_stt <= 1'b0;
               o_rx_stt <= 1'b0;
            end
         endcase
      end
   end

`ifdef TDD_ABORT_CNT_EN
   always_ff @(posedge clk_in) begin
      if (rst)
         o_abort_cnt <= '0;
      else if (o_abort && (o_abort_cnt != 16'hFFFF))
         o_abort_cnt <= o_abort_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_tdd_seq_ctrl.sv
// Bench for tdd_seq_ctrl: schedule-based model checked every cycle,
// plus directed literal checks of the key timing points.
module tb_tdd_seq_ctrl;

   localparam int AN = 4;
   localparam int CW = 12;
   localparam int ST = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tx_req = 1'b0;
   logic [AN-1:0] mask = 4'b1011;
   logic [CW-1:0] tx_guard = 12'd10;
   logic [CW-1:0] rx_guard = 12'd6;
   logic [AN-1:0] tx_en;
   logic [AN-1:0] rx_en;
   logic          tx_stt;
   logic          rx_stt;
   logic [2:0]    state;
   logic          abort;
`ifdef TDD_ABORT_CNT_EN
   logic [15:0]   abort_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   tdd_seq_ctrl #(.ANT_NUM(AN), .CNT_W(CW), .STEP(ST)) dut (
      .clk_in(clk),
      .rst(rst),
      .i_tx_req(tx_req),
      .i_ant_mask(mask),
      .i_tx_guard(tx_guard),
      .i_rx_guard(rx_guard),
      .o_tx_en(tx_en),
      .o_rx_en(rx_en),
      .o_tx_stt(tx_stt),
      .o_rx_stt(rx_stt),
      .o_state(state),
      .o_abort(abort)
`ifdef TDD_ABORT_CNT_EN
      ,
      .o_abort_cnt(abort_cnt)
`endif
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s @edge %0d: got %0h want %0h", nm, cyc, act, exp);
      end
   endtask

   // model: a direction entry at edge E defines a closed-form schedule
   logic          m_idle = 1'b1;
   logic          m_dir = 1'b0;
   logic          rq = 1'b0;
   logic          ab = 1'b0;
   logic [AN-1:0] m_mask = '0;
   int            m_r = 0;
   int            m_on = 0;
   int            m_acnt = 0;

   function automatic void start(input logic dir, input int e);
      int g;
      int p;
      g = dir ? int'(tx_guard) : int'(rx_guard);
      m_mask = mask;
      p = $countones(mask);
      m_dir = dir;
      m_idle = 1'b0;
      m_r = e + ((g < 1) ? 1 : g);
      m_on = (p >= 2) ? m_r + ST * (p - 1) : m_r + 1;
   endfunction

   function automatic int phase(input int t);
      if (t < m_r) return 0;
      if (t < m_on) return 1;
      return 2;
   endfunction

   function automatic logic [AN-1:0] en_at(input int t);
      logic [AN-1:0] en;
      int j;
      en = '0;
      j = 0;
      for (int i = 0; i < AN; i++) begin
         if (m_mask[i]) begin
            if (t >= m_r + ST * j) en[i] = 1'b1;
            j++;
         end
      end
      return en;
   endfunction

   initial begin
      logic [2:0]    e_st;
      logic [AN-1:0] e_tx;
      logic [AN-1:0] e_rx;
      logic          e_ts;
      logic          e_rs;
      int            ph;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_idle = 1'b1;
            m_acnt = 0;
            ab = 1'b0;
         end else begin
            if (ab && m_acnt != 16'hFFFF) m_acnt++;
            ab = 1'b0;
            if (m_idle) begin
               if (rq) start(1'b1, cyc);
            end else if (rq != m_dir) begin
               if (phase(cyc - 1) < 2) ab = 1'b1;
               start(rq, cyc);
            end
         end
         rq = tx_req;
         e_st = '0; e_tx = '0; e_rx = '0; e_ts = 0; e_rs = 0;
         if (!m_idle) begin
            ph = phase(cyc);
            e_st = (m_dir ? 3'd1 : 3'd4) + 3'(ph);
            if (m_dir) begin
               e_tx = en_at(cyc);
               e_ts = (ph == 2);
            end else begin
               e_rx = en_at(cyc);
               e_rs = (ph == 2);
            end
         end
         #1;
         chk("outputs", int'({state, tx_en, rx_en, tx_stt, rx_stt, abort}),
             int'({e_st, e_tx, e_rx, e_ts, e_rs, ab}));
         chk("exclusive", int'(tx_en & rx_en), 0);
`ifdef TDD_ABORT_CNT_EN
         chk("abort_cnt", int'(abort_cnt), m_acnt);
`endif
      end
   end

   task automatic at_edge(input int e);
      wait (cyc >= e);
      #2;
   endtask

   task automatic set_req(input logic v, output int e);
      @(negedge clk);
      tx_req = v;
      e = cyc + 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int e0;
      int e1;
      int e2;
      int e3;
      int e4;
      int e5;
      int e6;
      at_edge(3);
      chk("rst_state", int'(state), 0);
      chk("rst_en", int'({tx_en, rx_en, tx_stt, rx_stt, abort}), 0);
      @(negedge clk);
      rst = 1'b0;
      // basic TX ramp
      set_req(1'b1, e0);
      at_edge(e0 + 1);
      chk("tx_guard_state", int'(state), 1);
      at_edge(e0 + 11);
      chk("tx_en_1st", int'(tx_en), 4'b0001);
      chk("tx_ramp_state", int'(state), 2);
      at_edge(e0 + 13);
      chk("tx_en_2nd", int'(tx_en), 4'b0011);
      at_edge(e0 + 15);
      chk("tx_en_last", int'(tx_en), 4'b1011);
      chk("tx_on", int'({state, tx_stt}), {3'd3, 1'b1});
      at_edge(e0 + 17);
      // TX to RX
      set_req(1'b0, e1);
      at_edge(e1 + 1);
      chk("rx_guard_txoff", int'({state, tx_en}), {3'd4, 4'b0000});
      at_edge(e1 + 11);
      chk("rx_en_last", int'(rx_en), 4'b1011);
      chk("rx_on", int'({state, rx_stt}), {3'd6, 1'b1});
      at_edge(e1 + 13);
      // abort of TX ramp just before completion
      set_req(1'b1, e2);
      at_edge(e2 + 13);
      chk("abort_pre", int'(tx_en), 4'b0011);
      @(negedge clk);
      tx_req = 1'b0;
      at_edge(e2 + 15);
      chk("abort_pulse", int'({abort, tx_en, state, tx_stt}),
          {1'b1, 4'b0000, 3'd4, 1'b0});
      at_edge(e2 + 16);
      chk("abort_once", int'(abort), 0);
`ifdef TDD_ABORT_CNT_EN
      chk("abort_cnt_lit", int'(abort_cnt), 1);
`endif
      at_edge(e2 + 27);
      // zero mask, zero guard
      @(negedge clk);
      mask = 4'b0000;
      tx_guard = 12'd0;
      set_req(1'b1, e3);
      at_edge(e3 + 1);
      chk("z_guard", int'(state), 1);
      at_edge(e3 + 2);
      chk("z_ramp", int'({state, tx_en}), {3'd2, 4'b0000});
      at_edge(e3 + 3);
      chk("z_on", int'({state, tx_en, tx_stt}), {3'd3, 4'b0000, 1'b1});
      @(negedge clk);
      mask = 4'b1011;
      tx_guard = 12'd10;
      set_req(1'b0, e4);
      at_edge(e4 + 12);
      // mask change mid-ramp is ignored
      set_req(1'b1, e5);
      at_edge(e5 + 11);
      @(negedge clk);
      mask = 4'b1111;
      at_edge(e5 + 13);
      chk("mchg_2nd", int'(tx_en), 4'b0011);
      at_edge(e5 + 15);
      chk("mchg_last", int'({state, tx_en}), {3'd3, 4'b1011});
      @(negedge clk);
      mask = 4'b1011;
      at_edge(e5 + 17);
      // reset during RX ramp
      set_req(1'b0, e6);
      at_edge(e6 + 7);
      chk("rst_pre", int'(state), 5);
      @(negedge clk);
      rst = 1'b1;
      tx_req = 1'b1;
      at_edge(e6 + 8);
      chk("rst_mid", int'({state, tx_en, rx_en, tx_stt, rx_stt, abort}), 0);
      @(negedge clk);
      rst = 1'b0;
      at_edge(e6 + 9);
      chk("rst_resume", int'(state), 1);
      at_edge(e6 + 30);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
